// File: rtl/npe_pkg.sv
// Shared constants and packer state encoding for the NPE result requantization path.
package npe_pkg;

  localparam int NPE_LANE_IN_W  = 16;
  localparam int NPE_LANE_OUT_W = 8;
  localparam int NPE_QMAX       = 127;
  localparam int NPE_QMIN       = -128;

  typedef enum logic {
    PK_EMPTY = 1'b0,
    PK_HALF  = 1'b1
  } pk_state_e;

endpackage

// File: rtl/npe_result_fifo.sv
// Synchronous FIFO with a registered head word; a push that finds no room is dropped and reported.
module npe_result_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count, count_after_pop;
  logic             full, do_pop, do_push;

  assign empty           = (count == '0);
  assign full            = (count == CW'(DEPTH));
  assign do_pop          = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push         = push & (~full | do_pop);
  assign drop            = push & ~do_push;
  assign rd_ptr_n        = rd_ptr + AW'(do_pop);
  assign count_after_pop = count - CW'(do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_after_pop + CW'(do_push);
      if (do_push && count_after_pop == '0) head <= push_data;
      else if (do_pop)                      head <= mem[rd_ptr_n];
    end
  end

  // NOTE: storage is deliberately left unreset; only pointers and head are, so stale entries are never observable.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/npe_result_quant.sv
// Requantizes 16-bit NPE result lanes to int8 and packs vector pairs into write words for the memory writer.
module npe_result_quant
  import npe_pkg::*;
#(
  parameter int DATA_WIDTH  = NPE_LANE_OUT_W,
  parameter int DATA_COPIES = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_npe_result,
  input  logic                              i_npe_result_vld,
  input  logic [3:0]                        i_shift,
  input  logic                              i_relu_en,
  input  logic                              i_flush,
  output logic [DATA_COPIES*2*DATA_WIDTH-1:0] o_wr_data,
  output logic                              o_wr_vld,
  input  logic                              i_wr_rdy,
  output logic                              o_overflow,
  output logic                              o_busy
);

  localparam int IW = 2 * DATA_WIDTH;
  localparam int LW = IW + 1;
  localparam int HW = DATA_COPIES * DATA_WIDTH;
  localparam int WW = 2 * HW;
  localparam logic signed [LW-1:0] Q_HI = LW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [LW-1:0] Q_LO = ~Q_HI;

  logic [HW-1:0] q_next, q, lo;
  logic          q_vld, flush_d;
  pk_state_e     state;
  logic          push, fifo_empty, fifo_drop;
  logic [WW-1:0] push_word;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive limit.
  for (genvar k = 0; k < DATA_COPIES; k++) begin : g_lane
    logic signed [LW-1:0] x, rnd, t, y;
    always_comb begin
      x   = LW'($signed(i_npe_result[IW*k +: IW]));
      rnd = (i_shift == '0) ? '0 : (LW'(1) << (i_shift - 4'd1));
      t   = x + rnd;
      y   = t >>> i_shift;
      if (i_relu_en && y[LW-1]) y = '0;
      if (y > Q_HI)      y = Q_HI;
      else if (y < Q_LO) y = Q_LO;
    end
    assign q_next[DATA_WIDTH*k +: DATA_WIDTH] = y[DATA_WIDTH-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q       <= '0;
      q_vld   <= 1'b0;
      flush_d <= 1'b0;
    end else begin
      q_vld   <= i_npe_result_vld;
      flush_d <= i_flush;
      if (i_npe_result_vld) q <= q_next;
    end
  end

  // NOTE: defaults first so every path assigns push and push_word and no latch is inferred.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    case (state)
      PK_EMPTY: if (q_vld && flush_d) begin
        push      = 1'b1;
        push_word = {{HW{1'b0}}, q};
      end
      PK_HALF: if (q_vld) begin
        push      = 1'b1;
        push_word = {q, lo};
      end else if (flush_d) begin
        push      = 1'b1;
        push_word = {{HW{1'b0}}, lo};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= PK_EMPTY;
      lo    <= '0;
    end else begin
      case (state)
        PK_EMPTY: if (q_vld && !flush_d) begin
          lo    <= q;
          state <= PK_HALF;
        end
        PK_HALF:  if (q_vld || flush_d) state <= PK_EMPTY;
        default:  state <= PK_EMPTY;
      endcase
    end
  end

  npe_result_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (push),
    .push_data (push_word),
    .pop       (i_wr_rdy),
    .head      (o_wr_data),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          o_overflow <= 1'b0;
    else if (fifo_drop) o_overflow <= 1'b1;
  end

  assign o_wr_vld = ~fifo_empty;
  assign o_busy   = (state == PK_HALF) | q_vld | ~fifo_empty;

endmodule

// File: tb/tb_npe_result_quant.sv
// Directed and randomized checks of npe_result_quant against a queue-based reference model.
module tb_npe_result_quant;
  import npe_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [511:0] i_npe_result;
  logic         i_npe_result_vld;
  logic [3:0]   i_shift;
  logic         i_relu_en;
  logic         i_flush;
  logic [511:0] o_wr_data;
  logic         o_wr_vld;
  logic         i_wr_rdy;
  logic         o_overflow;
  logic         o_busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  bit           s1_vld;
  logic [255:0] s1_q;
  bit           s1_flush;
  logic [255:0] pend[$];
  logic [511:0] mq[$];
  bit           m_ovf;

  npe_result_quant dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_npe_result     (i_npe_result),
    .i_npe_result_vld (i_npe_result_vld),
    .i_shift          (i_shift),
    .i_relu_en        (i_relu_en),
    .i_flush          (i_flush),
    .o_wr_data        (o_wr_data),
    .o_wr_vld         (o_wr_vld),
    .i_wr_rdy         (i_wr_rdy),
    .o_overflow       (o_overflow),
    .o_busy           (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] quant_vec(input logic [511:0] v, input int sh, input bit relu);
    logic [255:0] r;
    int x, t, y;
    for (int k = 0; k < 32; k++) begin
      x = $signed(v[16*k +: 16]);
      t = x + ((sh > 0) ? (1 << (sh - 1)) : 0);
      y = t >>> sh;
      if (relu && y < 0) y = 0;
      if (y > NPE_QMAX) y = NPE_QMAX;
      if (y < NPE_QMIN) y = NPE_QMIN;
      r[8*k +: 8] = y[7:0];
    end
    return r;
  endfunction

  function automatic logic [511:0] fill16(input logic [15:0] v);
    return {32{v}};
  endfunction

  task automatic model_reset();
    s1_vld = 0; s1_q = '0; s1_flush = 0; m_ovf = 0;
    pend.delete();
    mq.delete();
  endtask

  // Called at each rising edge: the word formed from last cycle's vector enters the queue, then new inputs are captured.
  task automatic model_edge();
    logic [511:0] w;
    bit has_w;
    has_w = 0;
    w = '0;
    if (s1_vld) begin
      pend.push_back(s1_q);
      if (pend.size() == 2) begin
        w = {pend[1], pend[0]};
        has_w = 1;
        pend.delete();
      end
    end
    if (s1_flush && pend.size() == 1) begin
      w = {256'b0, pend[0]};
      has_w = 1;
      pend.delete();
    end
    if (mq.size() > 0 && i_wr_rdy) void'(mq.pop_front());
    if (has_w) begin
      if (mq.size() < 4) mq.push_back(w);
      else m_ovf = 1;
    end
    s1_vld   = i_npe_result_vld;
    s1_q     = quant_vec(i_npe_result, int'(i_shift), i_relu_en);
    s1_flush = i_flush;
  endtask

  task automatic check_all();
    bit busy_m;
    busy_m = (pend.size() > 0) || s1_vld || (mq.size() > 0);
    check("wr_vld", 512'(o_wr_vld), 512'(mq.size() > 0));
    if (mq.size() > 0) check("wr_data", o_wr_data, mq[0]);
    check("overflow", 512'(o_overflow), 512'(m_ovf));
    check("busy", 512'(o_busy), 512'(busy_m));
  endtask

  task automatic step();
    @(posedge i_clk);
    if (i_rst) model_reset();
    else model_edge();
    #1;
    if (!i_rst) check_all();
  endtask

  task automatic drive_vec(input logic [511:0] v, input logic [3:0] sh, input logic relu, input logic fl);
    i_npe_result     = v;
    i_shift          = sh;
    i_relu_en        = relu;
    i_flush          = fl;
    i_npe_result_vld = 1'b1;
    step();
    i_npe_result_vld = 1'b0;
    i_flush          = 1'b0;
  endtask

  task automatic pop_one();
    i_wr_rdy = 1'b1;
    step();
    i_wr_rdy = 1'b0;
  endtask

  initial begin
    logic [511:0] v, exp_w;
    logic [7:0]   b_lo, b_hi;
    int           s;

    i_rst = 1'b1;
    i_npe_result = '0; i_npe_result_vld = 0; i_shift = '0;
    i_relu_en = 0; i_flush = 0; i_wr_rdy = 0;
    step();
    step();
    i_rst = 1'b0;
    check("rst_vld", 512'(o_wr_vld), 512'(0));
    check("rst_data", o_wr_data, 512'(0));
    check("rst_ovf", 512'(o_overflow), 512'(0));
    check("rst_busy", 512'(o_busy), 512'(0));

    // Saturation both ways, word latency
    drive_vec(fill16(16'h0100), 4'd1, 1'b0, 1'b0);
    drive_vec(fill16(16'hFF80), 4'd0, 1'b0, 1'b0);
    check("pair_vld_n1", 512'(o_wr_vld), 512'(0));
    step();
    exp_w = {{32{8'h80}}, {32{8'h7F}}};
    check("pair_vld_n2", 512'(o_wr_vld), 512'(1));
    check("pair_data", o_wr_data, exp_w);
    pop_one();

    // Rounding and 17-bit headroom
    v = '0;
    v[15:0] = 16'h0003; v[31:16] = 16'hFFFD; v[47:32] = 16'h7FFF;
    drive_vec(v, 4'd1, 1'b0, 1'b0);
    v = '0;
    v[15:0] = 16'h4000;
    drive_vec(v, 4'd15, 1'b0, 1'b0);
    step();
    check("rnd_p3", 512'(o_wr_data[7:0]), 512'(8'h02));
    check("rnd_m3", 512'(o_wr_data[15:8]), 512'(8'h FF));
    check("rnd_max", 512'(o_wr_data[23:16]), 512'(8'h7F));
    check("rnd_sh15", 512'(o_wr_data[263:256]), 512'(8'h01));
    pop_one();

    // ReLU on and off
    v = '0;
    v[15:0] = 16'hFFFB;
    drive_vec(v, 4'd0, 1'b1, 1'b0);
    drive_vec(v, 4'd0, 1'b0, 1'b0);
    step();
    check("relu_on", 512'(o_wr_data[7:0]), 512'(8'h00));
    check("relu_off", 512'(o_wr_data[263:256]), 512'(8'hFB));
    pop_one();

    // Overflow: 5 words into a 4-deep FIFO, then drain
    for (int i = 0; i < 10; i++) drive_vec(fill16(16'(i)), 4'd0, 1'b0, 1'b0);
    step();
    check("ovf_set", 512'(o_overflow), 512'(1));
    check("ovf_vld", 512'(o_wr_vld), 512'(1));
    i_wr_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      b_lo = 8'(2 * j);
      b_hi = 8'(2 * j + 1);
      exp_w = {{32{b_hi}}, {32{b_lo}}};
      check("drain_word", o_wr_data, exp_w);
      step();
    end
    check("drain_empty", 512'(o_wr_vld), 512'(0));
    check("ovf_sticky", 512'(o_overflow), 512'(1));
    i_wr_rdy = 1'b0;

    // Reset while HALF with two words buffered
    for (int i = 0; i < 5; i++) drive_vec(fill16(16'(8'h11 + i)), 4'd0, 1'b0, 1'b0);
    step();
    check("pre_rst_busy", 512'(o_busy), 512'(1));
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_vld", 512'(o_wr_vld), 512'(0));
    check("mid_rst_busy", 512'(o_busy), 512'(0));
    check("mid_rst_ovf", 512'(o_overflow), 512'(0));
    check("mid_rst_data", o_wr_data, 512'(0));
    step();
    i_rst = 1'b0;
    drive_vec(fill16(16'h0021), 4'd0, 1'b0, 1'b0);
    drive_vec(fill16(16'h0022), 4'd0, 1'b0, 1'b0);
    step();
    exp_w = {{32{8'h22}}, {32{8'h21}}};
    check("post_rst_word", o_wr_data, exp_w);
    pop_one();

    // Flush a lone half-word, then a flush with nothing pending
    drive_vec(fill16(16'h0005), 4'd0, 1'b0, 1'b0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    step();
    exp_w = {256'b0, {32{8'h05}}};
    check("flush_vld", 512'(o_wr_vld), 512'(1));
    check("flush_word", o_wr_data, exp_w);
    pop_one();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    step();
    step();
    check("flush2_vld", 512'(o_wr_vld), 512'(0));
    check("flush2_busy", 512'(o_busy), 512'(0));

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 32; k++) begin
        if ($urandom_range(0, 3) == 0) i_npe_result[16*k +: 16] = 16'($urandom);
        else begin
          s = int'($urandom_range(0, 600)) - 300;
          i_npe_result[16*k +: 16] = 16'(s);
        end
      end
      i_npe_result_vld = ($urandom_range(0, 9) < 7);
      i_shift          = 4'($urandom_range(0, 15));
      i_relu_en        = 1'($urandom_range(0, 1));
      i_flush          = ($urandom_range(0, 9) == 0);
      i_wr_rdy         = ($urandom_range(0, 9) < 6);
      step();
    end
    i_npe_result_vld = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_wr_rdy = 1'b1;
    repeat (10) step();
    check("end_vld", 512'(o_wr_vld), 512'(0));
    check("end_busy", 512'(o_busy), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
